store_write_combine_buffer: RTL and testbench

//  Coalescing write buffer directly downstream of the store-commit pipeline and upstream of the DCache write port.
//  It accepts committed store writes (line address, replicated line data, byte enables) through a req/ack handshake.

---
 rtl/store_write_combine_buffer_pkg.sv | 34 +++
 rtl/store_write_buffer_probe.sv | 20 ++
 rtl/store_write_combine_buffer.sv | 162 ++++++++++++++++
 tb/tb_store_write_combine_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_write_combine_buffer_pkg.sv
// rtl/store_write_combine_buffer_pkg.sv - shared types and byte-merge helper for the store write-combine buffer
package LoadStoreUnitTypes;

   localparam int WB_ENTRY_NUM       = 4;
   localparam int WB_LINE_BYTE_NUM   = 8;
   localparam int WB_ADDR_WIDTH      = 32;
   localparam int WB_OFFSET_WIDTH    = $clog2(WB_LINE_BYTE_NUM);
   localparam int WB_LINE_ADDR_WIDTH = WB_ADDR_WIDTH - WB_OFFSET_WIDTH;

   typedef logic [$clog2(WB_ENTRY_NUM)-1:0] WriteBufferIndexPath;
   typedef logic [WB_LINE_ADDR_WIDTH-1:0]   LineAddrPath;
   typedef logic [WB_LINE_BYTE_NUM*8-1:0]   LineDataPath;
   typedef logic [WB_LINE_BYTE_NUM-1:0]     LineByteWEPath;

   typedef enum logic {WB_IDLE, WB_ISSUE} WriteBufferDrainState;

   typedef struct packed {
      logic          valid;
      logic          uncachable;
      LineAddrPath   lineAddr;
      LineDataPath   data;
      LineByteWEPath byteWE;
   } WriteBufferEntry;

   function automatic LineDataPath MergeLineBytes(input LineDataPath oldData,
                                                  input LineDataPath newData,
                                                  input LineByteWEPath newWE);
      LineDataPath merged;
      for (int b = 0; b < WB_LINE_BYTE_NUM; b++)
         merged[b*8 +: 8] = newWE[b] ? newData[b*8 +: 8] : oldData[b*8 +: 8];
      return merged;
   endfunction

endpackage

// File: rtl/store_write_buffer_probe.sv
// rtl/store_write_buffer_probe.sv - parallel line-address match of a load against all valid buffer entries
module store_write_buffer_probe
   import LoadStoreUnitTypes::*;
#(
   parameter int ENTRY_NUM = WB_ENTRY_NUM
) (
   input  logic                 valids [ENTRY_NUM],
   input  LineAddrPath          lineAddrs [ENTRY_NUM],
   input  LineAddrPath          probeLine,
   output logic                 probeHit
);

   always_comb begin
      probeHit = 1'b0;
      for (int i = 0; i < ENTRY_NUM; i++)
         if (valids[i] && lineAddrs[i] == probeLine)
            probeHit = 1'b1;
   end

endmodule

// File: rtl/store_write_combine_buffer.sv
// rtl/store_write_combine_buffer.sv - coalescing FIFO between store commit and the DCache write port
module store_write_combine_buffer
   import LoadStoreUnitTypes::*;
#(
   parameter int ENTRY_NUM     = WB_ENTRY_NUM,
   parameter int LINE_BYTE_NUM = WB_LINE_BYTE_NUM,
   parameter int ADDR_WIDTH    = WB_ADDR_WIDTH,
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           inReq,
   input  logic [ADDR_WIDTH-1:0]          inAddr,
   input  logic [LINE_BYTE_NUM*8-1:0]     inData,
   input  logic [LINE_BYTE_NUM-1:0]       inByteWE,
   input  logic                           inUncachable,
   output logic                           inAck,
   output logic                           outReq,
   output logic [ADDR_WIDTH-1:0]          outAddr,
   output logic [LINE_BYTE_NUM*8-1:0]     outData,
   output logic [LINE_BYTE_NUM-1:0]       outByteWE,
   output logic                           outUncachable,
   input  logic                           outAck,
   input  logic                           flush,
   input  logic [ADDR_WIDTH-1:0]          probeAddr,
   output logic                           probeHit,
   output logic                           empty,
   output logic [$clog2(ENTRY_NUM+1)-1:0] count
);

   localparam int OFFSET_W = $clog2(LINE_BYTE_NUM);
   localparam int IDX_W    = $clog2(ENTRY_NUM);
   localparam int CNT_W    = $clog2(ENTRY_NUM+1);
   localparam int TMR_W    = $clog2(DRAIN_TIMEOUT+1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ENTRY_NUM);
   localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO_COUNT  = CNT_W'(2);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ENTRY_NUM-1);
   localparam logic [TMR_W-1:0] TIMEOUT    = TMR_W'(DRAIN_TIMEOUT);

   WriteBufferEntry      entries [ENTRY_NUM];
   WriteBufferDrainState state, nextState;
   logic [IDX_W-1:0]     head, tail, youngest, headNext;
   logic [CNT_W-1:0]     countReg, countNext;
   logic [TMR_W-1:0]     timer;
   LineAddrPath          inLine;
   logic                 issuing, mergeOK, doWrite, doMerge, doAlloc, drain, headUncNext;
   logic                 probeValids [ENTRY_NUM];
   LineAddrPath          probeLines [ENTRY_NUM];
   logic                 unusedOffsets;

   // Pointer wrap by subtraction so ENTRY_NUM need not be a power of two.
   function automatic logic [IDX_W-1:0] IncIdx(input logic [IDX_W-1:0] idx);
      logic [IDX_W:0] sum;
      sum = {1'b0, idx} + (IDX_W+1)'(1);
      if (sum >= (IDX_W+1)'(ENTRY_NUM))
         sum = sum - (IDX_W+1)'(ENTRY_NUM);
      return sum[IDX_W-1:0];
   endfunction

   assign unusedOffsets = ^{inAddr[OFFSET_W-1:0], probeAddr[OFFSET_W-1:0]};
   assign issuing       = (state == WB_ISSUE);

   always_comb begin
      inLine   = inAddr[ADDR_WIDTH-1:OFFSET_W];
      youngest = (tail == '0) ? LAST_IDX : tail - IDX_W'(1);
      // The issuing head is frozen so outData stays stable until outAck.
      mergeOK  = (countReg != '0) && entries[youngest].valid &&
                 (entries[youngest].lineAddr == inLine) &&
                 !entries[youngest].uncachable && !inUncachable &&
                 !(issuing && youngest == head);
      inAck    = !rst && inReq && (mergeOK || countReg != FULL_COUNT);
      doWrite  = inAck && (inByteWE != '0);
      doMerge  = doWrite && mergeOK;
      doAlloc  = doWrite && !mergeOK;
      drain    = issuing && outAck;
      headNext = drain ? IncIdx(head) : head;
      countNext = countReg + (doAlloc ? ONE_COUNT : '0) - (drain ? ONE_COUNT : '0);
      headUncNext = entries[headNext].valid ? entries[headNext].uncachable : inUncachable;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRY_NUM; i++)
            entries[i] <= '0;
         head     <= '0;
         tail     <= '0;
         countReg <= '0;
         timer    <= '0;
      end else begin
         if (drain)
            entries[head].valid <= 1'b0;
         if (doMerge) begin
            entries[youngest].data   <= MergeLineBytes(entries[youngest].data, inData, inByteWE);
            entries[youngest].byteWE <= entries[youngest].byteWE | inByteWE;
         end
         if (doAlloc) begin
            entries[tail] <= '{valid: 1'b1, uncachable: inUncachable, lineAddr: inLine,
                               data: MergeLineBytes('0, inData, inByteWE), byteWE: inByteWE};
            tail <= IncIdx(tail);
         end
         head     <= headNext;
         countReg <= countNext;
         if (countReg == ONE_COUNT && !inAck && !drain)
            timer <= (timer == TIMEOUT) ? timer : timer + TMR_W'(1);
         else
            timer <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= WB_IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         WB_IDLE:
            if (countReg != '0 && (countReg >= TWO_COUNT || flush || countReg == FULL_COUNT ||
                                   entries[head].uncachable || timer >= TIMEOUT))
               nextState = WB_ISSUE;
         WB_ISSUE:
            if (drain)
               nextState = (countNext != '0 && (countNext >= TWO_COUNT || flush || headUncNext))
                           ? WB_ISSUE : WB_IDLE;
         default: nextState = WB_IDLE;
      endcase
   end

   always_comb begin
      outReq        = issuing;
      outAddr       = '0;
      outData       = '0;
      outByteWE     = '0;
      outUncachable = 1'b0;
      if (issuing) begin
         outAddr       = {entries[head].lineAddr, {OFFSET_W{1'b0}}};
         outData       = entries[head].data;
         outByteWE     = entries[head].byteWE;
         outUncachable = entries[head].uncachable;
      end
   end

   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         probeValids[i] = entries[i].valid;
         probeLines[i]  = entries[i].lineAddr;
      end
   end

   store_write_buffer_probe #(.ENTRY_NUM(ENTRY_NUM)) probe (
      .valids    (probeValids),
      .lineAddrs (probeLines),
      .probeLine (probeAddr[ADDR_WIDTH-1:OFFSET_W]),
      .probeHit  (probeHit)
   );

   assign empty = (countReg == '0);
   assign count = countReg;

endmodule

// File: tb/tb_store_write_combine_buffer.sv
// tb/tb_store_write_combine_buffer.sv - randomized and directed bench against a queue-based buffer model
module tb_store_write_combine_buffer;

   localparam int ENTRIES = 4;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inReq = 1'b0, inUncachable = 1'b0, outAck = 1'b0, flush = 1'b0;
   logic [31:0] inAddr = '0, probeAddr = '0;
   logic [63:0] inData = '0;
   logic [7:0]  inByteWE = '0;
   logic        inAck, outReq, outUncachable, probeHit, empty;
   logic [31:0] outAddr;
   logic [63:0] outData;
   logic [7:0]  outByteWE;
   logic [2:0]  count;

   store_write_combine_buffer dut (
      .clk(clk), .rst(rst), .inReq(inReq), .inAddr(inAddr), .inData(inData),
      .inByteWE(inByteWE), .inUncachable(inUncachable), .inAck(inAck),
      .outReq(outReq), .outAddr(outAddr), .outData(outData), .outByteWE(outByteWE),
      .outUncachable(outUncachable), .outAck(outAck), .flush(flush),
      .probeAddr(probeAddr), .probeHit(probeHit), .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [28:0] line;
      logic        unc;
      logic [63:0] data;
      logic [7:0]  we;
   } ModelEntry;

   typedef struct {
      logic [31:0] addr;
      logic        unc;
   } DrainRecord;

   ModelEntry  mq[$];
   DrainRecord drainLog[$];
   logic [31:0] expectAddrs[$];
   bit  mIssuing = 0;
   int  mTimer = 0;
   int  checks = 0, failures = 0;
   logic        sampAck, sampReq, sampEmpty, sampHit, sampUnc;
   logic [2:0]  sampCount;
   logic [31:0] sampAddr;
   logic [63:0] sampData;
   logic [7:0]  sampWE;

   task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      mIssuing = 0;
      mTimer = 0;
   endtask

   // Predict this cycle's outputs from the queue model, compare, then advance the model over the clock edge.
   task automatic evalModel();
      bit mergeOk, expAck, expHit, drained, headUncOld;
      int n;
      ModelEntry e;
      sampAck = inAck; sampReq = outReq; sampEmpty = empty; sampHit = probeHit;
      sampCount = count; sampAddr = outAddr; sampData = outData; sampWE = outByteWE; sampUnc = outUncachable;
      if (rst) begin
         checkValue("rst_inAck", inAck, 0);
         checkValue("rst_outReq", outReq, 0);
         checkValue("rst_empty", empty, 1);
         checkValue("rst_count", count, 0);
         modelReset();
         return;
      end
      n = mq.size();
      mergeOk = n > 0 && mq[n-1].line == inAddr[31:3] && !mq[n-1].unc && !inUncachable && !(mIssuing && n == 1);
      expAck = inReq && (mergeOk || n < ENTRIES);
      expHit = 0;
      foreach (mq[i]) if (mq[i].line == probeAddr[31:3]) expHit = 1;
      checkValue("inAck", inAck, expAck);
      checkValue("outReq", outReq, mIssuing);
      checkValue("count", count, n);
      checkValue("empty", empty, n == 0);
      checkValue("probeHit", probeHit, expHit);
      if (mIssuing) begin
         checkValue("outAddr", outAddr, {mq[0].line, 3'b000});
         checkValue("outData", outData, mq[0].data);
         checkValue("outByteWE", outByteWE, mq[0].we);
         checkValue("outUncachable", outUncachable, mq[0].unc);
      end else begin
         checkValue("outAddr_idle", outAddr, 0);
      end
      drained = mIssuing && outAck;
      headUncOld = (n > 0) ? mq[0].unc : 1'b0;
      if (expAck && inByteWE != 0) begin
         if (mergeOk) begin
            e = mq[n-1];
            for (int b = 0; b < 8; b++) if (inByteWE[b]) e.data[b*8 +: 8] = inData[b*8 +: 8];
            e.we = e.we | inByteWE;
            mq[n-1] = e;
         end else begin
            e.line = inAddr[31:3]; e.unc = inUncachable; e.we = inByteWE; e.data = '0;
            for (int b = 0; b < 8; b++) if (inByteWE[b]) e.data[b*8 +: 8] = inData[b*8 +: 8];
            mq.push_back(e);
         end
      end
      if (drained) begin
         drainLog.push_back('{addr: outAddr, unc: outUncachable});
         void'(mq.pop_front());
      end
      if (!mIssuing)
         mIssuing = n > 0 && (n >= 2 || flush || headUncOld || (n == 1 && mTimer >= TIMEOUT));
      else if (drained)
         mIssuing = mq.size() > 0 && (mq.size() >= 2 || flush || mq[0].unc);
      mTimer = (n == 1 && !expAck && !drained) ? ((mTimer + 1 > TIMEOUT) ? TIMEOUT : mTimer + 1) : 0;
   endtask

   task automatic step(input logic req, input logic [31:0] addr, input logic [63:0] data,
                       input logic [7:0] we, input logic unc, input logic oack,
                       input logic fl, input logic [31:0] paddr);
      inReq = req; inAddr = addr; inData = data; inByteWE = we;
      inUncachable = unc; outAck = oack; flush = fl; probeAddr = paddr;
      @(negedge clk);
      evalModel();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic oack, input logic fl, input logic [31:0] paddr);
      step(0, 32'h0, 64'h0, 8'h0, 0, oack, fl, paddr);
   endtask

   task automatic drainAll();
      for (int i = 0; i < 100 && (mq.size() > 0 || mIssuing); i++)
         idle(1, 1, 32'h0);
      checkValue("drain_done", mq.size() == 0 && !mIssuing, 1);
      idle(0, 0, 32'h0);
      checkValue("drain_empty", sampEmpty, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int accepted;
      logic [31:0] a;
      // reset held with a pending request
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 32'h40, 64'h1, 8'hFF, 0, 0, 0, 32'h40);
      rst = 1'b0;
      modelReset();

      // byte merge into a single line, then timeout-driven drain
      step(1, 32'h100, 64'hAAAA_AAAA_1122_3344, 8'h0F, 0, 0, 0, 32'h100);
      step(1, 32'h104, 64'h5566_7788_BBBB_BBBB, 8'hF0, 0, 0, 0, 32'h100);
      idle(0, 0, 32'h100);
      checkValue("t2_count", sampCount, 1);
      for (int i = 0; i < 15; i++) idle(0, 0, 32'h100);
      checkValue("t2_no_early_issue", sampReq, 0);
      for (int i = 0; i < 10 && !mIssuing; i++) idle(0, 0, 32'h100);
      idle(0, 0, 32'h100);
      checkValue("t2_outReq", sampReq, 1);
      checkValue("t2_outAddr", sampAddr, 32'h100);
      checkValue("t2_outByteWE", sampWE, 8'hFF);
      checkValue("t2_outData", sampData, 64'h5566_7788_1122_3344);
      idle(1, 0, 32'h100);
      idle(0, 0, 32'h100);
      checkValue("t2_empty", sampEmpty, 1);

      // full buffer back-pressure, including same-cycle outAck
      for (int i = 1; i <= 4; i++) step(1, 32'h1000 * i, 64'(i), 8'hFF, 0, 0, 0, 32'h0);
      step(1, 32'h5000, 64'h5, 8'hFF, 0, 0, 0, 32'h0);
      checkValue("t3_full_ack", sampAck, 0);
      step(1, 32'h5000, 64'h5, 8'hFF, 0, 1, 0, 32'h0);
      checkValue("t3_full_ack_outAck", sampAck, 0);
      step(1, 32'h5000, 64'h5, 8'hFF, 0, 0, 0, 32'h0);
      checkValue("t3_ack_after_free", sampAck, 1);
      idle(0, 0, 32'h0);
      checkValue("t3_count_full", sampCount, 4);
      drainAll();

      // streaming with outAck tied high: order preserved across pointer wrap
      drainLog.delete(); expectAddrs.delete(); accepted = 0;
      for (int i = 0; i < 100 && accepted < 10; i++) begin
         a = 32'h10000 + 32'(accepted) * 8;
         step(1, a, {$urandom, $urandom}, 8'hFF, 0, 1, 0, a);
         if (sampAck) begin expectAddrs.push_back(a); accepted++; end
      end
      drainAll();
      checkValue("t4_len", drainLog.size(), 10);
      foreach (expectAddrs[i])
         if (i < drainLog.size()) checkValue($sformatf("t4_order%0d", i), drainLog[i].addr, expectAddrs[i]);

      // uncachable entry never merges
      drainLog.delete();
      step(1, 32'h8000, 64'h11, 8'h01, 1, 0, 0, 32'h8000);
      step(1, 32'h8000, 64'h22, 8'h02, 0, 0, 0, 32'h8000);
      idle(0, 0, 32'h8000);
      checkValue("t5_count", sampCount, 2);
      drainAll();
      checkValue("t5_len", drainLog.size(), 2);
      if (drainLog.size() == 2) begin
         checkValue("t5_unc_first", drainLog[0].unc, 1);
         checkValue("t5_unc_second", drainLog[1].unc, 0);
         checkValue("t5_addr_second", drainLog[1].addr, 32'h8000);
      end

      // write to the issuing head's line allocates; probe; asynchronous reset
      step(1, 32'h200, 64'h33, 8'hFF, 0, 0, 1, 32'h204);
      idle(0, 1, 32'h204);
      step(1, 32'h200, 64'h44, 8'h0F, 0, 0, 0, 32'h204);
      checkValue("t6_head_issuing", sampReq, 1);
      idle(0, 0, 32'h204);
      checkValue("t6_count", sampCount, 2);
      checkValue("t6_probeHit", sampHit, 1);
      rst = 1'b1;
      #1;
      checkValue("t6_async_empty", empty, 1);
      checkValue("t6_async_outReq", outReq, 0);
      modelReset();
      @(posedge clk); #1;
      rst = 1'b0;

      // randomized traffic over a small set of lines
      for (int i = 0; i < 500; i++) begin
         logic [7:0] we;
         we = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
         step($urandom_range(0, 3) != 0, 32'h3000 + 32'($urandom_range(0, 5)) * 8 + 32'($urandom_range(0, 7)),
              {$urandom, $urandom}, we, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0, 32'h3000 + 32'($urandom_range(0, 7)) * 8 + 32'($urandom_range(0, 7)));
      end
      drainAll();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
